calc_entry: RTL and testbench
=============================

CALC_ENTRY -- requirements
Module: calc_entry

Interface
REQ-001 SHALL have parameter DIGITS, default 8, maximum operand digits accepted (legal 1..8).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port key_en  input  1  one-cycle key-press strobe from keypad scanner.
REQ-005 SHALL have port key_num  input  4  key code, valid only when key_en=1.
REQ-006 SHALL have port disp_bcd  output  32  eight BCD digits, [3:0] least significant.
REQ-007 SHALL have port disp_len  output  4  count of significant digits, 1..8; display blanks the rest.
REQ-008 SHALL have port disp_neg  output  1  displayed value is negative.
REQ-009 SHALL have port disp_err  output  1  overflow error shown.
REQ-010 SHALL have port busy  output  1  result computation/conversion in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a result first appears on disp_bcd.

Function
REQ-012 SHALL decode key codes: 0-9 digit, A add, B subtract, C multiply, D clear-entry, E equals, F clear-all.
REQ-013 SHALL implement states S_A (enter A), S_OP (operator held), S_B (enter B), S_CALC (one cycle), S_CONV (binary-to-BCD), S_RES, S_ERR.
REQ-014 SHALL keep each operand as BCD digits plus a 27-bit binary value; digit entry sets value=value*10+d and shifts BCD left one digit.
REQ-015 SHALL ignore digits when operand already holds DIGITS digits; a 0 entered into a zero operand keeps length 1.
REQ-016 SHALL update disp_* registered one cycle after the key_en cycle for entry/clear keys.
REQ-017 In S_A: digit appends to A; operator stores op, moves to S_OP; E ignored.
REQ-018 In S_OP: another operator replaces op; digit starts B with that digit, moves to S_B, display shows B; E ignored.
REQ-019 In S_B: digit appends to B; operator ignored; E moves to S_CALC, busy=1 from next cycle.
REQ-020 S_CALC SHALL compute A+B, |A-B| with neg=(A<B), or A*B (54-bit product); result >99,999,999 goes to S_ERR, else S_CONV.
REQ-021 S_CONV SHALL run double-dabble, 27 iterations one per cycle, then enter S_RES, drop busy, pulse done; total E-to-done latency exactly 29 cycles.
REQ-022 In S_RES: digit starts new A; operator with neg=0 loads result into A and moves to S_OP; operator with neg=1 and E ignored.
REQ-023 S_ERR SHALL show disp_bcd=0, disp_len=1, disp_err=1; digit starts new A, clears err; other keys except F ignored.
REQ-024 D SHALL zero the operand being entered (length 1) in S_A/S_B; ignored elsewhere.
REQ-025 F SHALL return to S_A with all registers zero from any state, including mid S_CONV; all other keys during S_CALC/S_CONV dropped.
REQ-026 key_num SHALL be ignored whenever key_en=0.

Reset
REQ-027 On rst low: state S_A, operands/op zero, disp_bcd=0, disp_len=1, disp_neg=0, disp_err=0, busy=0, done=0; asynchronous assert, synchronous-safe release.

Configuration
REQ-028 With CALC_MUL_EN defined, key C selects multiply; without it, key C is ignored in every state and no multiplier is synthesized.

Structure
REQ-029 Shared package calc_pkg SHALL hold key-code constants, operator encoding, state encoding, and MAX_VALUE=99,999,999.
REQ-030 Binary-to-BCD conversion SHALL be sub-module bin2bcd (start/done handshake, 27-bit in, 32-bit out, abortable).

Verification
REQ-031 Keys 1,2,A,3,4,E -> display 12, 34, then done 29 cycles after E, disp_bcd=0x00000046, disp_len=2.
REQ-032 Keys 5,B,9,E -> disp_bcd=0x4, disp_neg=1; then A ignored, digit 7 shows 7 with neg=0.
REQ-033 Keys 9x8,C,9x8,E (CALC_MUL_EN) -> disp_err=1, disp_bcd=0; key 3 -> shows 3, err=0; without macro C ignored, display 99999999 after ninth 9 ignored.
REQ-034 Nine digits 1 with DIGITS=8 -> disp_bcd=0x11111111, len=8; D -> 0, len=1.
REQ-035 Keys 8,A,2,E then F on cycle 10 of S_CONV -> busy=0, no done pulse, display 0.
REQ-036 rst low mid-entry (A=123) -> all outputs at reset values immediately; after release, key 4 -> display 4.

Source files
------------

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg -- shared definitions for the keypad calculator entry block.
//   Key codes, operator and FSM state encodings, the largest displayable value,
//   the operand record (BCD digits + binary value + digit count) and helpers
//   for digit entry and significant-digit counting.
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam logic [3:0]  KEY_ADD    = 4'hA;
    localparam logic [3:0]  KEY_SUB    = 4'hB;
    localparam logic [3:0]  KEY_MUL    = 4'hC;
    localparam logic [3:0]  KEY_CE     = 4'hD;
    localparam logic [3:0]  KEY_EQ     = 4'hE;
    localparam logic [3:0]  KEY_CA     = 4'hF;

    localparam logic [26:0] MAX_VALUE  = 27'd99_999_999;
    localparam int          CONV_STEPS = 27;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_OP   = 3'd1,
        S_B    = 3'd2,
        S_CALC = 3'd3,
        S_CONV = 3'd4,
        S_RES  = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    typedef struct packed {
        logic [31:0] bcd;
        logic [26:0] bin;
        logic [3:0]  len;
    } operand_t;

    localparam operand_t OPND_ZERO = '{bcd: 32'd0, bin: 27'd0, len: 4'd1};

    // Append one decimal digit; a zero operand is replaced rather than grown,
    // and a full operand is left untouched.
    function automatic operand_t enter_digit(input operand_t cur,
                                             input logic [3:0] d,
                                             input logic [3:0] max_len);
        operand_t nxt;
        nxt = cur;
        if (cur.bin == 27'd0) begin
            nxt.bcd = {28'd0, d};
            nxt.bin = {23'd0, d};
            nxt.len = 4'd1;
        end else if (cur.len < max_len) begin
            nxt.bcd = {cur.bcd[27:0], d};
            nxt.bin = (cur.bin * 27'd10) + {23'd0, d};
            nxt.len = cur.len + 4'd1;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    // Number of significant BCD digits (at least one, so zero shows "0").
    function automatic logic [3:0] bcd_len(input logic [31:0] v);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 1; i < 8; i++) begin
            n = (v[4*i +: 4] != 4'd0) ? 4'(i + 1) : n;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd -- sequential double-dabble converter, one iteration per clock.
//   clk, rst    : clock, asynchronous active-low reset
//   start_i     : load bin_i and begin a 27-step conversion
//   abort_i     : cancel any conversion in flight (wins over start_i)
//   bin_i[26:0] : binary value to convert
//   done_o      : one-cycle pulse once bcd_o holds the finished result
//   bcd_o[31:0] : eight BCD digits, [3:0] least significant
// -----------------------------------------------------------------------------
module bin2bcd
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [26:0] bin_i,
    output logic        done_o,
    output logic [31:0] bcd_o
);

    logic [31:0] bcd_q, bcd_d;
    logic [26:0] sh_q, sh_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic        done_q, done_d;
    logic [31:0] adj_s;

    // Add-3 correction of every digit that would overflow on the next shift
    always_comb begin
        adj_s = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // Next-state: abort beats start, start beats a running iteration
    always_comb begin
        bcd_d  = bcd_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (abort_i) begin
            run_d = 1'b0;
            cnt_d = 5'd0;
        end else if (start_i) begin
            bcd_d = 32'd0;
            sh_d  = bin_i;
            cnt_d = 5'd0;
            run_d = 1'b1;
        end else if (run_q) begin
            // shift {bcd, bin} left by one after correction
            bcd_d = {adj_s[30:0], sh_q[26]};
            sh_d  = {sh_q[25:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(CONV_STEPS - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                run_d  = 1'b1;
                done_d = 1'b0;
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Converter state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcd_q  <= 32'd0;
            sh_q   <= 27'd0;
            cnt_q  <= 5'd0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_entry.sv
// -----------------------------------------------------------------------------
// calc_entry -- keypad entry and result sequencing for a two-operand calculator.
//   clk, rst         : clock, asynchronous active-low reset
//   key_en, key_num  : one-cycle key strobe and key code (0-9, A..F)
//   disp_bcd/len/neg/err : registered display image
//   busy             : result computation or conversion in progress
//   done             : one-cycle pulse when a result first reaches the display
// Build option: define CALC_MUL_EN to enable key C (multiply); otherwise key C
// is ignored everywhere and no multiplier exists.
// -----------------------------------------------------------------------------
module calc_entry
    import calc_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_en,
    input  logic [3:0]  key_num,
    output logic [31:0] disp_bcd,
    output logic [3:0]  disp_len,
    output logic        disp_neg,
    output logic        disp_err,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] MAX_LEN = 4'(DIGITS);

    state_t      state_q, state_d;
    operand_t    a_q, a_d, b_q, b_d;
    op_t         op_q, op_d;
    logic [26:0] res_bin_q, res_bin_d;
    logic        res_neg_q, res_neg_d;
    logic [31:0] disp_bcd_q, disp_bcd_d;
    logic [3:0]  disp_len_q, disp_len_d;
    logic        disp_neg_q, disp_neg_d, disp_err_q, disp_err_d;
    logic        busy_q, busy_d, done_q, done_d;

    logic        key_digit_s, key_op_s, key_mul_s, key_ce_s, key_eq_s, key_ca_s;
    op_t         key_op_code_s;
    operand_t    a_next_s, b_next_s, new_s;
    logic [53:0] calc_val_s;
    logic        calc_neg_s, calc_ovf_s;
    logic        conv_start_s, conv_abort_s, conv_done_s;
    logic [31:0] conv_bcd_s;

`ifdef CALC_MUL_EN
    assign key_mul_s = key_en && (key_num == KEY_MUL);
`else
    assign key_mul_s = 1'b0;
`endif

    assign key_digit_s = key_en && (key_num <= 4'd9);
    assign key_op_s    = key_mul_s || (key_en && ((key_num == KEY_ADD) || (key_num == KEY_SUB)));
    assign key_ce_s    = key_en && (key_num == KEY_CE);
    assign key_eq_s    = key_en && (key_num == KEY_EQ);
    assign key_ca_s    = key_en && (key_num == KEY_CA);

    assign a_next_s = enter_digit(a_q, key_num, MAX_LEN);
    assign b_next_s = enter_digit(b_q, key_num, MAX_LEN);
    assign new_s    = enter_digit(OPND_ZERO, key_num, MAX_LEN);

    // Operator code for the pressed key
    always_comb begin
        key_op_code_s = OP_ADD;
        case (key_num)
            KEY_SUB: key_op_code_s = OP_SUB;
            KEY_MUL: key_op_code_s = OP_MUL;
            default: key_op_code_s = OP_ADD;
        endcase
    end

    // Arithmetic on the held operands; subtraction yields magnitude plus sign
    always_comb begin
        calc_val_s = 54'd0;
        calc_neg_s = 1'b0;
        case (op_q)
            OP_ADD: calc_val_s = 54'(a_q.bin) + 54'(b_q.bin);
            OP_SUB: begin
                if (a_q.bin < b_q.bin) begin
                    calc_val_s = 54'(b_q.bin - a_q.bin);
                    calc_neg_s = 1'b1;
                end else begin
                    calc_val_s = 54'(a_q.bin - b_q.bin);
                    calc_neg_s = 1'b0;
                end
            end
`ifdef CALC_MUL_EN
            OP_MUL: calc_val_s = 54'(a_q.bin) * 54'(b_q.bin);
`endif
            default: calc_val_s = 54'd0;
        endcase
    end

    assign calc_ovf_s = (calc_val_s > 54'(MAX_VALUE));

    bin2bcd u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start_s),
        .abort_i (conv_abort_s),
        .bin_i   (calc_val_s[26:0]),
        .done_o  (conv_done_s),
        .bcd_o   (conv_bcd_s)
    );

    // Next-state and display logic of the entry FSM
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        res_bin_d    = res_bin_q;
        res_neg_d    = res_neg_q;
        disp_bcd_d   = disp_bcd_q;
        disp_len_d   = disp_len_q;
        disp_neg_d   = disp_neg_q;
        disp_err_d   = disp_err_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        conv_start_s = 1'b0;
        conv_abort_s = 1'b0;

        if (key_ca_s) begin
            state_d      = S_A;
            a_d          = OPND_ZERO;
            b_d          = OPND_ZERO;
            op_d         = OP_ADD;
            res_bin_d    = 27'd0;
            res_neg_d    = 1'b0;
            disp_bcd_d   = 32'd0;
            disp_len_d   = 4'd1;
            disp_neg_d   = 1'b0;
            disp_err_d   = 1'b0;
            busy_d       = 1'b0;
            conv_abort_s = 1'b1;
        end else begin
            case (state_q)
                S_A: begin
                    if (key_digit_s) begin
                        a_d        = a_next_s;
                        disp_bcd_d = a_next_s.bcd;
                        disp_len_d = a_next_s.len;
                    end else if (key_op_s) begin
                        op_d    = key_op_code_s;
                        state_d = S_OP;
                    end else if (key_ce_s) begin
                        a_d        = OPND_ZERO;
                        disp_bcd_d = 32'd0;
                        disp_len_d = 4'd1;
                    end else begin
                        state_d = S_A;
                    end
                end
                S_OP: begin
                    if (key_digit_s) begin
                        b_d        = new_s;
                        disp_bcd_d = new_s.bcd;
                        disp_len_d = new_s.len;
                        state_d    = S_B;
                    end else if (key_op_s) begin
                        op_d = key_op_code_s;
                    end else begin
                        state_d = S_OP;
                    end
                end
                S_B: begin
                    if (key_digit_s) begin
                        b_d        = b_next_s;
                        disp_bcd_d = b_next_s.bcd;
                        disp_len_d = b_next_s.len;
                    end else if (key_ce_s) begin
                        b_d        = OPND_ZERO;
                        disp_bcd_d = 32'd0;
                        disp_len_d = 4'd1;
                    end else if (key_eq_s) begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_B;
                    end
                end
                S_CALC: begin
                    if (calc_ovf_s) begin
                        state_d    = S_ERR;
                        busy_d     = 1'b0;
                        disp_bcd_d = 32'd0;
                        disp_len_d = 4'd1;
                        disp_neg_d = 1'b0;
                        disp_err_d = 1'b1;
                    end else begin
                        state_d      = S_CONV;
                        conv_start_s = 1'b1;
                        res_bin_d    = calc_val_s[26:0];
                        res_neg_d    = calc_neg_s;
                    end
                end
                S_CONV: begin
                    if (conv_done_s) begin
                        state_d    = S_RES;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        disp_bcd_d = conv_bcd_s;
                        disp_len_d = bcd_len(conv_bcd_s);
                        disp_neg_d = res_neg_q;
                        disp_err_d = 1'b0;
                    end else begin
                        state_d = S_CONV;
                    end
                end
                S_RES, S_ERR: begin
                    if (key_digit_s) begin
                        state_d    = S_A;
                        a_d        = new_s;
                        b_d        = OPND_ZERO;
                        res_neg_d  = 1'b0;
                        disp_bcd_d = new_s.bcd;
                        disp_len_d = new_s.len;
                        disp_neg_d = 1'b0;
                        disp_err_d = 1'b0;
                    end else if (key_op_s && (state_q == S_RES) && !res_neg_q) begin
                        // chain: the shown result becomes operand A
                        a_d     = '{bcd: disp_bcd_q, bin: res_bin_q, len: disp_len_q};
                        op_d    = key_op_code_s;
                        state_d = S_OP;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
    end

    // Entry FSM and display registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_A;
            a_q        <= OPND_ZERO;
            b_q        <= OPND_ZERO;
            op_q       <= OP_ADD;
            res_bin_q  <= 27'd0;
            res_neg_q  <= 1'b0;
            disp_bcd_q <= 32'd0;
            disp_len_q <= 4'd1;
            disp_neg_q <= 1'b0;
            disp_err_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_bin_q  <= res_bin_d;
            res_neg_q  <= res_neg_d;
            disp_bcd_q <= disp_bcd_d;
            disp_len_q <= disp_len_d;
            disp_neg_q <= disp_neg_d;
            disp_err_q <= disp_err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign disp_bcd = disp_bcd_q;
    assign disp_len = disp_len_q;
    assign disp_neg = disp_neg_q;
    assign disp_err = disp_err_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_calc_entry.sv
// -----------------------------------------------------------------------------
// tb_calc_entry -- directed key sequences with hand-computed display images.
// Stimulus pushes {due cycle, expected outputs} into a queue; a monitor on the
// falling edge pops every entry that falls due and compares it with the DUT.
// Build with or without CALC_MUL_EN.
// -----------------------------------------------------------------------------
module tb_calc_entry;

    logic        clk;
    logic        rst;
    logic        key_en;
    logic [3:0]  key_num;
    logic [31:0] disp_bcd;
    logic [3:0]  disp_len;
    logic        disp_neg, disp_err, busy, done;

    calc_entry #(.DIGITS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_en   (key_en),
        .key_num  (key_num),
        .disp_bcd (disp_bcd),
        .disp_len (disp_len),
        .disp_neg (disp_neg),
        .disp_err (disp_err),
        .busy     (busy),
        .done     (done)
    );

    typedef struct {
        int          due;
        int          id;
        logic [39:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc       = 0;
    int   total     = 0;
    int   bad       = 0;
    int   next_id   = 0;
    int   exp_done  = 0;
    int   done_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (bcd,len,neg,err,busy,done)", nm, act, want);
        end
    endtask

    task automatic push(input int due, input logic [31:0] b, input logic [3:0] l,
                        input logic n, input logic e, input logic bz, input logic dn);
        exp_t x;
        x.due = due;
        x.id  = next_id;
        x.val = {b, l, n, e, bz, dn};
        next_id++;
        if (dn) exp_done++;
        exp_q.push_back(x);
    endtask

    // Monitor: count done pulses and compare every expectation that is due
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) done_seen++;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            if (e.due < cyc) begin
                total++;
                bad++;
                $display("FAIL stale#%0d: due=%0d now=%0d", e.id, e.due, cyc);
            end else begin
                chk($sformatf("disp#%0d", e.id),
                    {disp_bcd, disp_len, disp_neg, disp_err, busy, done}, e.val);
            end
        end
    end

    task automatic press(input logic [3:0] k, input logic [31:0] b, input logic [3:0] l,
                         input logic n, input logic e);
        @(negedge clk);
        key_en  = 1'b1;
        key_num = k;
        push(cyc + 1, b, l, n, e, 1'b0, 1'b0);
        @(negedge clk);
        key_en  = 1'b0;
        key_num = 4'h0;
    endtask

    // E with a result expected: busy from the next cycle, done 29 cycles later
    task automatic eq_run(input logic [31:0] pb, input logic [3:0] pl,
                          input logic [31:0] rb, input logic [3:0] rl, input logic rn);
        int c;
        @(negedge clk);
        c       = cyc;
        key_en  = 1'b1;
        key_num = 4'hE;
        push(c + 1,  pb, pl, 1'b0, 1'b0, 1'b1, 1'b0);
        push(c + 29, pb, pl, 1'b0, 1'b0, 1'b1, 1'b0);
        push(c + 30, rb, rl, rn,   1'b0, 1'b0, 1'b1);
        push(c + 31, rb, rl, rn,   1'b0, 1'b0, 1'b0);
        @(negedge clk);
        key_en  = 1'b0;
        key_num = 4'h0;
        repeat (31) @(negedge clk);
    endtask

    initial begin
        logic [31:0] ev;
        int          c;
        rst     = 1'b0;
        key_en  = 1'b0;
        key_num = 4'h0;

        // reset state, then key_num activity with key_en low is ignored
        @(negedge clk);
        chk("rst_init", {disp_bcd, disp_len, disp_neg, disp_err, busy, done},
            {32'h0, 4'd1, 4'b0000});
        rst     = 1'b1;
        key_num = 4'h9;
        push(cyc + 2, 32'h0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        key_num = 4'h0;

        // 12 + 34 = 46
        press(4'h1, 32'h1,  4'd1, 1'b0, 1'b0);
        press(4'h2, 32'h12, 4'd2, 1'b0, 1'b0);
        press(4'hA, 32'h12, 4'd2, 1'b0, 1'b0);
        press(4'h3, 32'h3,  4'd1, 1'b0, 1'b0);
        press(4'h4, 32'h34, 4'd2, 1'b0, 1'b0);
        eq_run(32'h34, 4'd2, 32'h46, 4'd2, 1'b0);

        // chain from result: 46 + 8 = 54
        press(4'hA, 32'h46, 4'd2, 1'b0, 1'b0);
        press(4'h8, 32'h8,  4'd1, 1'b0, 1'b0);
        eq_run(32'h8, 4'd1, 32'h54, 4'd2, 1'b0);

        // 5 - 9 = -4; operator on negative result ignored; digit starts anew
        press(4'h5, 32'h5, 4'd1, 1'b0, 1'b0);
        press(4'hB, 32'h5, 4'd1, 1'b0, 1'b0);
        press(4'h9, 32'h9, 4'd1, 1'b0, 1'b0);
        eq_run(32'h9, 4'd1, 32'h4, 4'd1, 1'b1);
        press(4'hA, 32'h4, 4'd1, 1'b1, 1'b0);
        press(4'h7, 32'h7, 4'd1, 1'b0, 1'b0);

        // 7 - 0 5 = 2: leading zero of B is replaced
        press(4'hB, 32'h7, 4'd1, 1'b0, 1'b0);
        press(4'h0, 32'h0, 4'd1, 1'b0, 1'b0);
        press(4'h5, 32'h5, 4'd1, 1'b0, 1'b0);
        eq_run(32'h5, 4'd1, 32'h2, 4'd1, 1'b0);

        // zero entry keeps length 1; nine 1s saturate at eight; D clears
        press(4'hF, 32'h0, 4'd1, 1'b0, 1'b0);
        press(4'h0, 32'h0, 4'd1, 1'b0, 1'b0);
        press(4'h0, 32'h0, 4'd1, 1'b0, 1'b0);
        ev = 32'h0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) ev = {ev[27:0], 4'h1};
            press(4'h1, ev, (i < 8) ? 4'(i + 1) : 4'd8, 1'b0, 1'b0);
        end
        press(4'hD, 32'h0, 4'd1, 1'b0, 1'b0);

        // nine 9s into A
        ev = 32'h0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) ev = {ev[27:0], 4'h9};
            press(4'h9, ev, (i < 8) ? 4'(i + 1) : 4'd8, 1'b0, 1'b0);
        end
`ifdef CALC_MUL_EN
        press(4'hC, 32'h99999999, 4'd8, 1'b0, 1'b0);
        ev = 32'h0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) ev = {ev[27:0], 4'h9};
            press(4'h9, ev, (i < 8) ? 4'(i + 1) : 4'd8, 1'b0, 1'b0);
        end
        @(negedge clk);
        c       = cyc;
        key_en  = 1'b1;
        key_num = 4'hE;
        push(c + 1,  32'h99999999, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        push(c + 2,  32'h0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        push(c + 30, 32'h0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        key_en  = 1'b0;
        key_num = 4'h0;
        repeat (30) @(negedge clk);
        press(4'hA, 32'h0, 4'd1, 1'b0, 1'b1);
        press(4'h3, 32'h3, 4'd1, 1'b0, 1'b0);
        press(4'hC, 32'h3, 4'd1, 1'b0, 1'b0);
        press(4'h7, 32'h7, 4'd1, 1'b0, 1'b0);
        eq_run(32'h7, 4'd1, 32'h21, 4'd2, 1'b0);
`else
        press(4'hC, 32'h99999999, 4'd8, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            press(4'h9, 32'h99999999, 4'd8, 1'b0, 1'b0);
        end
        press(4'hE, 32'h99999999, 4'd8, 1'b0, 1'b0);
        push(cyc + 28, 32'h99999999, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (29) @(negedge clk);
        press(4'hF, 32'h0, 4'd1, 1'b0, 1'b0);
        press(4'h3, 32'h3, 4'd1, 1'b0, 1'b0);
`endif

        // 8 + 2, aborted by F on the tenth conversion cycle
        press(4'hF, 32'h0, 4'd1, 1'b0, 1'b0);
        press(4'h8, 32'h8, 4'd1, 1'b0, 1'b0);
        press(4'hA, 32'h8, 4'd1, 1'b0, 1'b0);
        press(4'h2, 32'h2, 4'd1, 1'b0, 1'b0);
        @(negedge clk);
        c       = cyc;
        key_en  = 1'b1;
        key_num = 4'hE;
        push(c + 1, 32'h2, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        key_en  = 1'b0;
        key_num = 4'h0;
        repeat (10) @(negedge clk);
        key_en  = 1'b1;
        key_num = 4'hF;
        push(c + 12, 32'h0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(c + 30, 32'h0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(c + 31, 32'h0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        key_en  = 1'b0;
        key_num = 4'h0;
        repeat (21) @(negedge clk);

        // converter usable again after abort: 7 + 5 = 12
        press(4'h7, 32'h7, 4'd1, 1'b0, 1'b0);
        press(4'hA, 32'h7, 4'd1, 1'b0, 1'b0);
        press(4'h5, 32'h5, 4'd1, 1'b0, 1'b0);
        eq_run(32'h5, 4'd1, 32'h12, 4'd2, 1'b0);

        // asynchronous reset in the middle of entering 123
        press(4'h1, 32'h1,   4'd1, 1'b0, 1'b0);
        press(4'h2, 32'h12,  4'd2, 1'b0, 1'b0);
        press(4'h3, 32'h123, 4'd3, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("rst_async", {disp_bcd, disp_len, disp_neg, disp_err, busy, done},
               {32'h0, 4'd1, 4'b0000});
        repeat (2) @(negedge clk);
        rst = 1'b1;
        press(4'h4, 32'h4, 4'd1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("done_count", 40'(done_seen), 40'(exp_done));
        chk("queue_empty", 40'(exp_q.size()), 40'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
